emu_step_ctrl: RTL and testbench

Parametrised emulation clock-step controller: the multi-channel, multi-mode successor of the single-step clock generator used in analog-model emulation benches. It converts VIO-driven go/stop requests into per-channel clock-enable pulses supporting single-step, N-step burst and free-run. It sits between the VIO and the svreal-based model instances, one enable per model clock domain, all on the one emulator clock.

---
 rtl/emu_step_ctrl.sv | 155 +++++++++++++++
 tb/tb_emu_step_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/emu_step_ctrl.sv
// emu_step_ctrl: emulation clock-step controller.
// Turns go/stop requests into per-channel clock-enable pulses for
// single-step, N-step burst and free-run operation.
// Build option: define EMU_STEP_CTRL_SYNC_EN to pass go_i/stop_i through
// two-flop synchronisers (adds two cycles to every go/stop latency).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a go rising edge, no enables
// ST_RUN   | step cycles in progress (clk_en_o = latched mask)
// ST_DONE  | one-cycle done_o pulse, back to idle next cycle

module emu_step_ctrl #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_i,
    input  logic              stop_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  steps_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  step_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_FREE   = 2'd2;

    logic go_s;
    logic stop_s;

`ifdef EMU_STEP_CTRL_SYNC_EN
    logic go_meta_q;
    logic go_sync_q;
    logic stop_meta_q;
    logic stop_sync_q;

    // Two-flop synchronisers for the asynchronous go/stop sources.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            go_meta_q   <= 1'b0;
            go_sync_q   <= 1'b0;
            stop_meta_q <= 1'b0;
            stop_sync_q <= 1'b0;
        end else begin
            go_meta_q   <= go_i;
            go_sync_q   <= go_meta_q;
            stop_meta_q <= stop_i;
            stop_sync_q <= stop_meta_q;
        end
    end

    assign go_s   = go_sync_q;
    assign stop_s = stop_sync_q;
`else
    assign go_s   = go_i;
    assign stop_s = stop_i;
`endif

    state_t              state_q;
    logic                go_prev_q;
    logic [1:0]          mode_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [CNT_W-1:0]    rem_q;
    logic [NUM_CH-1:0]   clk_en_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    count_q;

    logic start_evt;
    assign start_evt = go_s & ~go_prev_q;

    // Run FSM with registered outputs; the first step is issued on the
    // start edge itself, so the remaining counter is loaded with N-1 there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            go_prev_q <= 1'b0;
            mode_q    <= MODE_SINGLE;
            mask_q    <= '0;
            rem_q     <= '0;
            clk_en_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            go_prev_q <= go_s;
            case (state_q)
                ST_IDLE: begin
                    clk_en_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    if (start_evt && !stop_s) begin
                        mode_q <= (mode_i == 2'd3) ? MODE_SINGLE : mode_i;
                        mask_q <= ch_mask_i;
                        busy_q <= 1'b1;
                        if (mode_i == MODE_BURST && steps_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            rem_q   <= '0;
                        end else begin
                            state_q  <= ST_RUN;
                            clk_en_q <= ch_mask_i;
                            count_q  <= count_q + CNT_W'(1);
                            rem_q    <= (mode_i == MODE_BURST) ? steps_i - CNT_W'(1) : '0;
                        end
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b1;
                    if (stop_s || (mode_q != MODE_FREE && rem_q == '0)) begin
                        state_q  <= ST_DONE;
                        clk_en_q <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        clk_en_q <= mask_q;
                        count_q  <= count_q + CNT_W'(1);
                        if (mode_q == MODE_BURST) begin
                            rem_q <= rem_q - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    clk_en_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    clk_en_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en_o     = clk_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign step_count_o = count_q;

endmodule

// File: tb/tb_emu_step_ctrl.sv
// Directed bench for emu_step_ctrl (main instance plus a 4-bit counter
// instance for wrap and maximum-burst behaviour).

module tb_emu_step_ctrl;

`ifdef EMU_STEP_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        go    = 1'b0;
    logic        stop  = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [15:0] steps = 16'd0;
    logic [1:0]  mask  = 2'b00;
    logic [1:0]  clk_en;
    logic        busy;
    logic        done;
    logic [15:0] cnt;

    logic        go_w    = 1'b0;
    logic [1:0]  mode_w  = 2'd0;
    logic [3:0]  steps_w = 4'd0;
    logic [1:0]  mask_w  = 2'b10;
    logic [1:0]  en_w;
    logic        busy_w;
    logic        done_w;
    logic [3:0]  cnt_w;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    emu_step_ctrl #(.NUM_CH(2), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go_i         (go),
        .stop_i       (stop),
        .mode_i       (mode),
        .steps_i      (steps),
        .ch_mask_i    (mask),
        .clk_en_o     (clk_en),
        .busy_o       (busy),
        .done_o       (done),
        .step_count_o (cnt)
    );

    emu_step_ctrl #(.NUM_CH(2), .CNT_W(4)) u_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .go_i         (go_w),
        .stop_i       (1'b0),
        .mode_i       (mode_w),
        .steps_i      (steps_w),
        .ch_mask_i    (mask_w),
        .clk_en_o     (en_w),
        .busy_o       (busy_w),
        .done_o       (done_w),
        .step_count_o (cnt_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One run: go rises before tick 1; stop (if stop_at >= 0) is raised
    // before tick stop_at+1; a go re-edge is attempted at tick regos.
    // Expected tick numbers are for the unsynchronised build, shifted by LAT.
    task automatic do_run(input string tag, input logic [1:0] m, input logic [15:0] n,
                          input logic [1:0] mk, input int stop_at, input int regos,
                          input int exp_en, input int exp_first, input int exp_done);
        int n_en    = 0;
        int first   = -1;
        int done_at = -1;
        int bad     = 0;
        int n_done  = 0;
        int post    = 0;
        mode  = m;
        steps = n;
        mask  = mk;
        go    = 1'b1;
        for (int c = 1; c <= 60 && done_at < 0; c++) begin
            if (c == stop_at + 1) stop = 1'b1;
            if (c == regos) go = 1'b0;
            if (c == regos + 1) go = 1'b1;
            if (c == 2) begin
                mask  = ~mk;
                steps = 16'd0;
            end
            tick;
            if (clk_en != 2'b00) begin
                n_en++;
                if (first < 0) first = c;
                if (clk_en !== mk || busy !== 1'b1) bad++;
            end
            if (done) begin
                done_at = c;
                n_done++;
            end
        end
        stop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (clk_en != 2'b00) post++;
            if (done) n_done++;
        end
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        go = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (clk_en != 2'b00) post++;
        end
        exp_cnt += exp_en;
        check({tag, ".n_en"}, n_en, exp_en);
        check({tag, ".first_en"}, first, exp_first);
        check({tag, ".done_at"}, done_at, exp_done);
        check({tag, ".en_value"}, bad, 0);
        check({tag, ".done_pulses"}, n_done, 1);
        check({tag, ".extra_en"}, post, 0);
        check({tag, ".count"}, 32'(cnt), exp_cnt);
    endtask

    initial begin
        int bad;
        int n_en;

        // Reset held with go toggling.
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            go = ~go;
            tick;
            if ({clk_en, busy, done, cnt} !== '0) bad++;
        end
        check("reset.outputs", bad, 0);
        go    = 1'b0;
        rst_n = 1'b1;
        repeat (2 + LAT) tick;
        check("reset.count_after", 32'(cnt), 32'd0);
        check("reset.en_after", 32'(clk_en), 32'd0);

        do_run("single", 2'd0, 16'd0, 2'b11, -1, 0, 1, 1 + LAT, 2 + LAT);
        do_run("mode3", 2'd3, 16'd9, 2'b10, -1, 0, 1, 1 + LAT, 2 + LAT);
        do_run("burst5", 2'd1, 16'd5, 2'b01, -1, 3, 5, 1 + LAT, 6 + LAT);
        do_run("burst0", 2'd1, 16'd0, 2'b11, -1, 0, 0, -1, 1 + LAT);
        do_run("burst1", 2'd1, 16'd1, 2'b10, -1, 0, 1, 1 + LAT, 2 + LAT);
        do_run("free10", 2'd2, 16'd0, 2'b11, 10, 5, 10, 1 + LAT, 11 + LAT);
        do_run("burst20s7", 2'd1, 16'd20, 2'b01, 7, 0, 7, 1 + LAT, 8 + LAT);

        // Start coinciding with stop is discarded.
        bad  = 0;
        mode = 2'd2;
        mask = 2'b11;
        stop = 1'b1;
        go   = 1'b1;
        repeat (5 + LAT) begin
            tick;
            if (busy || clk_en != 2'b00 || done) bad++;
        end
        check("stop_start.idle", bad, 0);
        check("stop_start.count", 32'(cnt), exp_cnt);
        go   = 1'b0;
        stop = 1'b0;
        repeat (4) tick;

        // Reset in the middle of a burst.
        mode  = 2'd1;
        steps = 16'd20;
        mask  = 2'b11;
        go    = 1'b1;
        repeat (3 + LAT) tick;
        check("midrst.en_before", 32'(clk_en), 32'd3);
        rst_n = 1'b0;
        tick;
        check("midrst.en", 32'(clk_en), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.count", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        go    = 1'b0;
        bad   = 0;
        repeat (4 + LAT) begin
            if (done || clk_en != 2'b00) bad++;
            tick;
        end
        check("midrst.no_done", bad, 0);

        // 4-bit counter wrap after 17 single steps.
        mode_w = 2'd0;
        for (int i = 0; i < 17; i++) begin
            go_w = 1'b1;
            repeat (3 + LAT) tick;
            go_w = 1'b0;
            repeat (3 + LAT) tick;
        end
        check("wrap.count", 32'(cnt_w), 32'd1);

        // Maximum burst length for a 4-bit counter.
        mode_w  = 2'd1;
        steps_w = 4'd15;
        go_w    = 1'b1;
        n_en    = 0;
        bad     = 0;
        repeat (30) begin
            tick;
            if (en_w != 2'b00) begin
                n_en++;
                if (en_w !== 2'b10) bad++;
            end
        end
        go_w = 1'b0;
        check("maxburst.n_en", n_en, 15);
        check("maxburst.en_value", bad, 0);
        check("maxburst.count", 32'(cnt_w), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
